// File: rtl/neuron_pkg.sv
// Shared types and default sizing for the neuron sequencer, datapath and bench.
package neuron_pkg;

  localparam int unsigned NEURON_N = 16;
  localparam int unsigned NEURON_Q = 8;
  localparam int unsigned NEURON_D = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_LOAD,
    S_XW,
    S_MAC,
    S_RESULT,
    S_DONE
  } seq_state_t;

endpackage

// File: rtl/neuron_sequencer.sv
// Control and operand feed for the neuron datapath: clear, d handshaked
// (x, w) loads with MAC strobes, then result commit and a done pulse.
module neuron_sequencer
  import neuron_pkg::*;
#(
  parameter int unsigned N = NEURON_N,
  parameter int unsigned Q = NEURON_Q,
  parameter int unsigned d = NEURON_D
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_x,
  input  logic [N-1:0] in_w,
  output logic [N-1:0] x_data,
  output logic [N-1:0] w_data,
  output logic         x_write,
  output logic         w_write,
  output logic         clear_acc,
  output logic         acc_en,
  output logic         res_write,
  output logic         af_ready,
  output logic         busy,
  output logic         done
);

  localparam int unsigned IW = (d > 1) ? $clog2(d) : 1;
  localparam logic [IW-1:0] LAST = IW'(d - 1);
  localparam bit CfgOk = (Q < N) && (d >= 1);

  // Q only documents the operand format; no logic depends on it.
  if (!CfgOk) begin : g_cfg_invalid
  end

  seq_state_t    state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [N-1:0]  x_q, x_d;
  logic [N-1:0]  w_q, w_d;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      x_q     <= '0;
      w_q     <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      x_q     <= x_d;
      w_q     <= w_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    x_d       = x_q;
    w_d       = w_q;
    in_ready  = 1'b0;
    x_write   = 1'b0;
    w_write   = 1'b0;
    clear_acc = 1'b0;
    acc_en    = 1'b0;
    res_write = 1'b0;
    af_ready  = 1'b0;
    done      = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) state_d = S_CLEAR;
      end
      S_CLEAR: begin
        clear_acc = 1'b1;
        idx_d     = '0;
        state_d   = S_LOAD;
      end
      S_LOAD: begin
        in_ready = 1'b1;
        if (in_valid) begin
          x_d     = in_x;
          w_d     = in_w;
          state_d = S_XW;
        end
      end
      S_XW: begin
        x_write = 1'b1;
        w_write = 1'b1;
        state_d = S_MAC;
      end
      S_MAC: begin
        acc_en = 1'b1;
        if (idx_q == LAST) begin
          state_d = S_RESULT;
        end else begin
          idx_d   = idx_q + IW'(1);
          state_d = S_LOAD;
        end
      end
      S_RESULT: begin
        res_write = 1'b1;
        af_ready  = 1'b1;
        state_d   = S_DONE;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy   = (state_q != S_IDLE);
  assign x_data = x_q;
  assign w_data = w_q;

endmodule

// File: tb/tb_neuron_sequencer.sv
// Randomized bench for neuron_sequencer against a cycle-schedule model
// built from the evaluation timing rules.
module tb_neuron_sequencer;
  import neuron_pkg::*;

  localparam int D = NEURON_D;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, in_valid;
  logic [15:0] in_x, in_w;
  logic        in_ready, x_write, w_write, clear_acc;
  logic        acc_en, res_write, af_ready, busy, done;
  logic [15:0] x_data, w_data;

  logic        s1_start, s1_valid;
  logic [15:0] s1_x, s1_w;
  logic        r1_rdy, r1_xw, r1_ww, r1_clr, r1_acc;
  logic        r1_res, r1_af, r1_busy, r1_done;
  logic [15:0] r1_xd, r1_wd;

  always #5 clk = ~clk;

  neuron_sequencer u_dut (
    .clk(clk), .rst(rst), .start(start),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_x(in_x), .in_w(in_w),
    .x_data(x_data), .w_data(w_data),
    .x_write(x_write), .w_write(w_write),
    .clear_acc(clear_acc), .acc_en(acc_en),
    .res_write(res_write), .af_ready(af_ready),
    .busy(busy), .done(done)
  );

  neuron_sequencer #(.d(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(s1_start),
    .in_valid(s1_valid), .in_ready(r1_rdy),
    .in_x(s1_x), .in_w(s1_w),
    .x_data(r1_xd), .w_data(r1_wd),
    .x_write(r1_xw), .w_write(r1_ww),
    .clear_acc(r1_clr), .acc_en(r1_acc),
    .res_write(r1_res), .af_ready(r1_af),
    .busy(r1_busy), .done(r1_done)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // {in_ready, x_write, w_write, clear_acc, acc_en, res_write, af_ready, busy, done}
  function automatic logic [8:0] dut_s();
    return {in_ready, x_write, w_write, clear_acc, acc_en,
            res_write, af_ready, busy, done};
  endfunction

  function automatic logic [8:0] mk(bit rdy, bit xw, bit clr,
                                    bit acc, bit res, bit dn);
    return {rdy, xw, xw, clr, acc, res, res, 1'b1, dn};
  endfunction

  typedef struct {
    logic [8:0]  s;
    logic [15:0] x;
    logic [15:0] w;
    int          kind;
    int          pk;
  } cyc_t;

  cyc_t        plan[$];
  logic [15:0] lx = '0;
  logic [15:0] lw = '0;

  task automatic push(logic [8:0] s, int kind, int pk);
    cyc_t e;
    e.s = s; e.x = lx; e.w = lw; e.kind = kind; e.pk = pk;
    plan.push_back(e);
  endtask

  task automatic rnd_in();
    in_valid = 1'($urandom);
    in_x     = 16'($urandom);
    in_w     = 16'($urandom);
  endtask

  task automatic idle_cycles(int n);
    for (int i = 0; i < n; i++) begin
      start = 1'b0;
      rnd_in();
      @(posedge clk); #1;
      chk("idle_ctrl", dut_s(), 0);
      chk("idle_x", x_data, lx);
      chk("idle_w", w_data, lw);
    end
  endtask

  // noise: 0 none, 1 start at cycles 3 and 9, 2 random start while busy
  task automatic run_eval(input logic [15:0] px[D], input logic [15:0] pw[D],
                          input int stl[D], input int noise, input bit chain,
                          output int done_at);
    int n_done;
    plan.delete();
    push(mk(0, 0, 1, 0, 0, 0), 0, 0);
    for (int k = 0; k < D; k++) begin
      for (int j = 0; j < stl[k]; j++) push(mk(1, 0, 0, 0, 0, 0), 1, k);
      push(mk(1, 0, 0, 0, 0, 0), 2, k);
      lx = px[k];
      lw = pw[k];
      push(mk(0, 1, 0, 0, 0, 0), 0, k);
      push(mk(0, 0, 0, 1, 0, 0), 0, k);
    end
    push(mk(0, 0, 0, 0, 1, 0), 0, 0);
    push(mk(0, 0, 0, 0, 0, 1), 0, 0);

    done_at = -1;
    n_done = 0;
    start = 1'b1;
    rnd_in();
    @(posedge clk); #1;
    for (int c = 1; c <= plan.size(); c++) begin
      cyc_t e;
      e = plan[c-1];
      chk($sformatf("ctrl@%0d", c), dut_s(), e.s);
      chk($sformatf("x@%0d", c), x_data, e.x);
      chk($sformatf("w@%0d", c), w_data, e.w);
      if (done) begin
        n_done++;
        done_at = c;
      end
      if (c == plan.size()) start = chain;
      else if (noise == 1) start = (c == 3 || c == 9);
      else if (noise == 2) start = 1'($urandom);
      else start = 1'b0;
      rnd_in();
      if (e.kind == 1) in_valid = 1'b0;
      if (e.kind == 2) begin
        in_valid = 1'b1;
        in_x = px[e.pk];
        in_w = pw[e.pk];
      end
      @(posedge clk); #1;
    end
    chk("post_idle_ctrl", dut_s(), 0);
    chk("post_idle_x", x_data, lx);
    chk("done_count", n_done, 1);
  endtask

  logic [15:0] px[D], pw[D];
  int          stl[D];
  int          dat;
  logic [8:0]  exp1[1:7];

  initial begin
    rst = 1'b0;
    start = 1'b0; in_valid = 1'b0; in_x = '0; in_w = '0;
    s1_start = 1'b0; s1_valid = 1'b1; s1_x = 16'h1234; s1_w = 16'h5678;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_ctrl", dut_s(), 0);
    chk("rst_x", x_data, 0);
    chk("rst_w", w_data, 0);
    rst = 1'b1;
    in_valid = 1'b1; in_x = 16'hAAAA; in_w = 16'h5555;
    @(posedge clk); #1;
    chk("idle_nocap_x", x_data, 0);
    chk("idle_nocap_w", w_data, 0);
    idle_cycles(2);

    px = '{16'h0100, 16'h0080, 16'hFF00, 16'h0000};
    pw = '{16'h0200, 16'h0100, 16'h0100, 16'h7FFF};
    stl = '{0, 0, 0, 0};
    run_eval(px, pw, stl, 0, 1'b0, dat);
    chk("nominal_done_cycle", dat, 15);
    idle_cycles(1);

    stl = '{0, 0, 5, 0};
    run_eval(px, pw, stl, 0, 1'b0, dat);
    chk("stall_done_cycle", dat, 20);
    idle_cycles(1);

    stl = '{0, 0, 0, 0};
    run_eval(px, pw, stl, 1, 1'b0, dat);
    chk("restart_ignored_done", dat, 15);
    idle_cycles(1);

    start = 1'b1;
    rnd_in();
    @(posedge clk); #1;
    for (int c = 1; c < 8; c++) begin
      chk("abort_no_done", done, 0);
      start = 1'b0;
      rnd_in();
      in_valid = 1'b1;
      if (c == 7) rst = 1'b0;
      @(posedge clk); #1;
    end
    rst = 1'b1;
    lx = '0;
    lw = '0;
    chk("abort_ctrl", dut_s(), 0);
    chk("abort_x", x_data, 0);
    chk("abort_w", w_data, 0);
    run_eval(px, pw, stl, 0, 1'b0, dat);
    chk("after_abort_done", dat, 15);

    for (int r = 0; r < 10; r++) begin
      bit ch;
      for (int k = 0; k < D; k++) begin
        px[k] = 16'($urandom);
        pw[k] = 16'($urandom);
        stl[k] = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 3);
      end
      ch = (r % 3 == 0) && (r < 9);
      run_eval(px, pw, stl, $urandom_range(0, 2), ch, dat);
      if (!ch) idle_cycles($urandom_range(0, 2));
    end
    idle_cycles(1);

    exp1[1] = 9'b000100010;
    exp1[2] = 9'b100000010;
    exp1[3] = 9'b011000010;
    exp1[4] = 9'b000010010;
    exp1[5] = 9'b000001110;
    exp1[6] = 9'b000000011;
    exp1[7] = 9'b000000000;
    s1_start = 1'b1;
    @(posedge clk); #1;
    s1_start = 1'b0;
    for (int c = 1; c <= 7; c++) begin
      chk($sformatf("d1_ctrl@%0d", c),
          {r1_rdy, r1_xw, r1_ww, r1_clr, r1_acc,
           r1_res, r1_af, r1_busy, r1_done}, exp1[c]);
      @(posedge clk); #1;
    end
    chk("d1_x", r1_xd, 16'h1234);
    chk("d1_w", r1_wd, 16'h5678);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
